// File: rtl/ccw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ccw_sequencer
// Description : Issues one channel command word (address, command, byte
//               count) to a channel. Moves bytes src->channel or
//               channel->dst through one-byte holding registers and reports
//               the residual count on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module ccw_sequencer #(
    parameter int COUNT_WIDTH = 16,
    parameter int RUN_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             req_addr,
    input  logic [7:0]             req_command,
    input  logic [COUNT_WIDTH-1:0] req_count,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic                   done_valid,
    output logic [COUNT_WIDTH-1:0] done_residual,
    output logic                   done_timeout,
    output logic [7:0]             ch_addr,
    output logic [7:0]             ch_command,
    output logic                   ch_start,
    output logic                   ch_stop,
    input  logic                   ch_idle,
    output logic [7:0]             ch_send_tdata,
    output logic                   ch_send_tvalid,
    input  logic                   ch_send_tready,
    input  logic [7:0]             ch_recv_tdata,
    input  logic                   ch_recv_tvalid,
    output logic                   ch_recv_tready,
    input  logic [7:0]             src_tdata,
    input  logic                   src_tvalid,
    output logic                   src_tready,
    output logic [7:0]             dst_tdata,
    output logic                   dst_tvalid,
    input  logic                   dst_tready
);

    localparam int                RT_W     = $clog2(RUN_TIMEOUT + 1);
    localparam logic [RT_W-1:0]   RUN_LAST = RT_W'(RUN_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]             state_q,   state_d;
    logic [7:0]             addr_q,    addr_d;
    logic [7:0]             cmd_q,     cmd_d;
    logic [COUNT_WIDTH-1:0] count_q,   count_d;
    logic                   guard_q,   guard_d;
    logic [RT_W-1:0]        run_cnt_q, run_cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   snd_full_q, snd_full_d;
    logic [7:0]             snd_data_q, snd_data_d;
    logic                   rcv_full_q, rcv_full_d;
    logic [7:0]             rcv_data_q, rcv_data_d;

    logic w_active;
    logic w_count_nz;
    logic w_snd_xfer;
    logic w_rcv_xfer;
    logic w_src_xfer;
    logic w_dst_xfer;
    logic w_run_expire;
    logic w_zero_stop;

    // Data paths are only live while the channel is being serviced
    assign w_active   = (state_q == S_GUARD) || (state_q == S_RUN);
    assign w_count_nz = (count_q != '0);

    assign req_ready      = (state_q == S_IDLE);
    assign ch_start       = (state_q == S_START);
    assign done_valid     = (state_q == S_DONE);
    assign done_residual  = count_q;
    assign done_timeout   = timeout_q;
    assign ch_addr        = addr_q;
    assign ch_command     = cmd_q;

    // A byte still held at completion must never reach the channel
    assign ch_send_tvalid = w_active && snd_full_q;
    assign ch_send_tdata  = snd_data_q;
    // Fetch from src only when the channel is asking for data right now
    assign src_tready     = w_active && !snd_full_q && w_count_nz && ch_send_tready;
    assign ch_recv_tready = w_active && !rcv_full_q && w_count_nz;
    assign dst_tvalid     = rcv_full_q;
    assign dst_tdata      = rcv_data_q;

    assign w_snd_xfer = ch_send_tvalid && ch_send_tready;
    assign w_rcv_xfer = ch_recv_tvalid && ch_recv_tready;
    assign w_src_xfer = src_tvalid && src_tready;
    assign w_dst_xfer = dst_tvalid && dst_tready;

    // Channel still wants data after the count is exhausted: stop it
    assign w_zero_stop  = w_active && !w_count_nz && (ch_send_tready || ch_recv_tvalid);
    assign w_run_expire = (state_q == S_RUN) && !ch_idle && (run_cnt_q == RUN_LAST);
    assign ch_stop      = w_zero_stop || w_run_expire;

    // Next-state logic for the sequencer FSM, count and holding registers
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cmd_d      = cmd_q;
        count_d    = count_q;
        guard_d    = guard_q;
        run_cnt_d  = run_cnt_q;
        timeout_d  = timeout_q;
        snd_full_d = snd_full_q;
        snd_data_d = snd_data_q;
        rcv_full_d = rcv_full_q;
        rcv_data_d = rcv_data_q;

        // Saturating decrement: one per byte moved, two when both move
        if (w_snd_xfer && w_rcv_xfer) begin
            count_d = (count_q >= COUNT_WIDTH'(2)) ? count_q - COUNT_WIDTH'(2) : '0;
        end else if (w_snd_xfer || w_rcv_xfer) begin
            count_d = w_count_nz ? count_q - COUNT_WIDTH'(1) : '0;
        end

        if (w_snd_xfer) begin
            snd_full_d = 1'b0;
        end
        if (w_src_xfer) begin
            snd_full_d = 1'b1;
            snd_data_d = src_tdata;
        end
        if (w_dst_xfer) begin
            rcv_full_d = 1'b0;
        end
        if (w_rcv_xfer) begin
            rcv_full_d = 1'b1;
            rcv_data_d = ch_recv_tdata;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    cmd_d     = req_command;
                    count_d   = req_count;
                    timeout_d = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                guard_d = 1'b0;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                // Channel may not have left IDLE yet, so ch_idle is ignored here
                guard_d = 1'b1;
                if (guard_q) begin
                    run_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + RT_W'(1);
                if (ch_idle) begin
                    state_d = S_DONE;
                end else if (w_run_expire) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                snd_full_d = 1'b0;
                rcv_full_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 8'h00;
            cmd_q      <= 8'h00;
            count_q    <= '0;
            guard_q    <= 1'b0;
            run_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            snd_full_q <= 1'b0;
            snd_data_q <= 8'h00;
            rcv_full_q <= 1'b0;
            rcv_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            count_q    <= count_d;
            guard_q    <= guard_d;
            run_cnt_q  <= run_cnt_d;
            timeout_q  <= timeout_d;
            snd_full_q <= snd_full_d;
            snd_data_q <= snd_data_d;
            rcv_full_q <= rcv_full_d;
            rcv_data_q <= rcv_data_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/ccw_sequencer.md
CCW_SEQUENCER -- requirements
Module: ccw_sequencer

Interface
REQ-001 Parameter COUNT_WIDTH, default 16: width of the byte count and residual.
REQ-002 Parameter RUN_TIMEOUT, default 65535: maximum RUN cycles before a forced stop.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_addr/req_command  in  8/8  device address and CCW command code.
REQ-006 req_count  in  COUNT_WIDTH  byte count; req_valid in 1, req_ready out 1: request handshake.
REQ-007 done_valid  out  1  one-cycle completion pulse; done_residual out COUNT_WIDTH; done_timeout out 1.
REQ-008 ch_addr/ch_command  out  8/8; ch_start, ch_stop  out  1: drive channel addr/command/start/stop.
REQ-009 ch_idle  in  1  high while the channel is in its IDLE state.
REQ-010 ch_send_tdata out 8, ch_send_tvalid out 1, ch_send_tready in 1: bytes to channel.
REQ-011 ch_recv_tdata in 8, ch_recv_tvalid in 1, ch_recv_tready out 1: bytes from channel.
REQ-012 src_tdata in 8, src_tvalid in 1, src_tready out 1: upstream write-data stream.
REQ-013 dst_tdata out 8, dst_tvalid out 1, dst_tready in 1: downstream read-data stream.

Function
REQ-014 States IDLE, START, GUARD, RUN, DONE; encoding free.
REQ-015 IDLE: req_ready=1; on req_valid latch addr, command and count into registers, go START.
REQ-016 ch_addr/ch_command are driven from the latched registers and stay stable from START until the next accepted request.
REQ-017 START: ch_start=1 for exactly one cycle, then GUARD.
REQ-018 GUARD: 2 cycles, ch_idle ignored, data paths active; then RUN.
REQ-019 RUN: ch_idle=1 -> DONE; RUN cycle counter reaching RUN_TIMEOUT -> ch_stop pulse, done_timeout set, DONE.
REQ-020 DONE: done_valid=1 for one cycle with done_residual = remaining count; clear both holding registers; go IDLE.
REQ-021 Send holding register (1 byte): in GUARD/RUN, when empty, count!=0 and ch_send_tready=1 -> src_tready=1 and load on src_tvalid.
REQ-022 ch_send_tvalid = send holding full; held with data stable until ch_send_tready; transfer decrements count by 1.
REQ-023 Receive holding register (1 byte): ch_recv_tready=1 when empty, count!=0, state GUARD/RUN.
REQ-024 On ch_recv_tvalid&ch_recv_tready capture byte and decrement count; dst_tvalid = holding full; clear on dst_tready.
REQ-025 Count never decrements below 0; simultaneous send and receive transfers in one cycle decrement by 2 (saturating at 0).
REQ-026 count==0 and (ch_send_tready or ch_recv_tvalid) in GUARD/RUN -> ch_stop=1 for one cycle, repeated each such cycle.
REQ-027 req_count=0: no data moved; first channel data request answered with ch_stop.
REQ-028 A byte fetched from src but not accepted by the channel at DONE is discarded and not counted.
REQ-029 done_timeout holds until next request acceptance; req_valid outside IDLE ignored.

Reset
REQ-030 Reset asserted (any state, mid-transfer included): state IDLE, count 0, holding registers empty, ch_start/ch_stop/ch_send_tvalid/ch_recv_tready/src_tready/dst_tvalid/done_valid/done_timeout = 0, ch_addr/ch_command = 8'h00, done_residual = 0.
REQ-031 First request accepted on the first clock edge after reset release with req_valid=1.

Verification
REQ-032 Channel + mock CU at 8'h1a, limit 16; READ 8'h02 count 6 -> 6 bytes on dst, ch_stop issued, done_residual=0.
REQ-033 Limit 6; READ count 16 -> 6 bytes on dst, done_residual=10, done_timeout=0.
REQ-034 Limit 16; WRITE 8'h01 count 6, src supplies 8'h99 -> CU receives 6 bytes, done_residual=0; limit 6 count 16 -> residual 10.
REQ-035 Address 8'h10 (no CU) READ count 6 -> done_valid within 40 cycles, done_residual=6, no bytes on dst.
REQ-036 NOP 8'h03 count 0 -> done_residual=0; channel never sees send/recv transfer.
REQ-037 Reset asserted mid-WRITE after 3 bytes -> all outputs at REQ-030 values immediately; next request completes normally.
